// File: rtl/lif_pkg.sv
// lif_pkg: shared types and helpers for the leaky integrate-and-fire stage.
//
// Contents:
//   lif_state_t   - integration / refractory state of the neuron
//   DEFAULT_N     - default membrane width
//   LEAK_EN       - 1 when the build macro LIF_LEAK_EN is defined, else 0
//   lif_saturate  - clamps an (n+1)-bit adder sum to n bits
//   lif_leak      - applies x - (x >> shift) when leak is enabled
//
// Optional feature macro: LIF_LEAK_EN (enables membrane leak).
package lif_pkg;

  localparam int DEFAULT_N = 4;

  // Leak is resolved once here so every user sees the same build choice.
`ifdef LIF_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } lif_state_t;

  // The adder carry (bit n) means the true sum no longer fits, so the
  // membrane pins at full scale instead of wrapping around.
  function automatic logic [31:0] lif_saturate(input logic [32:0] sum,
                                               input int unsigned n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    if (((sum >> n) & 33'd1) != 33'd0)
      return mask;
    else
      return sum[31:0] & mask;
  endfunction

  // x - (x >> shift) can never go below zero because the shifted term
  // is never larger than x itself.
  function automatic logic [31:0] lif_leak(input logic [31:0] x,
                                           input int unsigned shift,
                                           input bit en);
    if (en)
      return x - (x >> shift);
    else
      return x;
  endfunction

endpackage

// File: rtl/lif_refrac_timer.sv
// lif_refrac_timer: loadable down-counter that measures the refractory
// period in neuron time steps.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - loads load_val (has priority over dec)
//   load_val - value loaded on load
//   dec      - decrements the count by one, stopping at zero
//   count    - current count
//   zero     - high when count is zero
module lif_refrac_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over decrement; decrement stops at zero so a stray dec
  // can never wrap the counter back to full scale.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lif_membrane_stage.sv
// lif_membrane_stage: registered membrane-potential stage of a leaky
// integrate-and-fire neuron. Consumes the (N+1)-bit sum of an external
// adder whose A operand is mem_out and whose B operand is the synaptic
// current; saturates, optionally leaks, thresholds and fires.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   step_valid  - one-cycle strobe marking a time step
//   sum_in      - adder sum, bit N is the carry
//   thresh      - firing threshold, sampled with step_valid
//   mem_out     - registered membrane potential (feeds adder A)
//   spike       - one-cycle spike pulse
//   sat         - one-cycle pulse when the sum saturated
//   refrac      - high while in the refractory state
//   spike_count - saturating count of spikes since reset
//
// Optional feature macro: LIF_LEAK_EN (applies x - (x >> LEAK_SHIFT)).
import lif_pkg::*;

module lif_membrane_stage #(
  parameter int N            = DEFAULT_N,
  parameter int REFRAC_STEPS = 2,
  parameter int LEAK_SHIFT   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  input  logic [N:0]       sum_in,
  input  logic [N-1:0]     thresh,
  output logic [N-1:0]     mem_out,
  output logic             spike,
  output logic             sat,
  output logic             refrac,
  output logic [CNT_W-1:0] spike_count
);

  localparam int TW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  lif_state_t    state;
  logic [N-1:0]  sat_val;
  logic [N-1:0]  leak_val;
  logic          fire;
  logic          timer_load;
  logic          timer_dec;
  logic [TW-1:0] timer_count;
  logic          timer_zero;
  logic          refrac_last;

  // Datapath ahead of the membrane register: clamp, leak, then compare.
  always_comb begin
    sat_val  = N'(lif_saturate(33'(sum_in), N));
    leak_val = N'(lif_leak(32'(sat_val), LEAK_SHIFT, LEAK_EN));
    fire     = (leak_val >= thresh);
  end

  // The timer is armed by a firing step and counts down on each
  // refractory step; the step that brings it to zero is the last one.
  always_comb begin
    timer_load  = step_valid && (state == INTEG) && fire && (REFRAC_STEPS > 0);
    timer_dec   = step_valid && (state == REFRACT);
    refrac_last = (timer_count == TW'(1)) || timer_zero;
  end

  lif_refrac_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TW'(REFRAC_STEPS)),
    .dec      (timer_dec),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // Neuron state machine. spike and sat are pulses, so they clear on
  // every cycle unless a step sets them; everything else holds between
  // steps. During refractory the sum is ignored and the membrane is
  // kept at rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INTEG;
      mem_out     <= '0;
      spike       <= 1'b0;
      sat         <= 1'b0;
      spike_count <= '0;
    end else begin
      spike <= 1'b0;
      sat   <= 1'b0;
      if (step_valid) begin
        case (state)
          INTEG: begin
            sat <= sum_in[N];
            if (fire) begin
              mem_out <= '0;
              spike   <= 1'b1;
              if (spike_count != '1)
                spike_count <= spike_count + CNT_W'(1);
              if (REFRAC_STEPS > 0)
                state <= REFRACT;
            end else begin
              mem_out <= leak_val;
            end
          end
          REFRACT: begin
            mem_out <= '0;
            if (refrac_last)
              state <= INTEG;
          end
          default: state <= INTEG;
        endcase
      end
    end
  end

  assign refrac = (state == REFRACT);

endmodule

// File: tb/tb_lif_membrane_stage.sv
// tb_lif_membrane_stage: self-checking bench for lif_membrane_stage.
// A step-level neuron model predicts every output; a compare process
// checks the DUT against it on each cycle, and directed scenarios add
// hand-computed literal expectations.
//
// Optional feature macro: LIF_LEAK_EN (model and directed cases follow it).
module tb_lif_membrane_stage;

  localparam int N      = 4;
  localparam int RS     = 2;
  localparam int LSHIFT = 2;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step_valid = 1'b0;
  logic [N:0]    sum_in = '0;
  logic [N-1:0]  thresh = '0;
  logic [N-1:0]  mem_out;
  logic          spike;
  logic          sat;
  logic          refrac;
  logic [CW-1:0] spike_count;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Neuron model in plain integers
  int m_mem = 0, m_cnt = 0, m_rem = 0;
  bit m_spike = 0, m_sat = 0, m_inref = 0;
  int e_mem = 0, e_cnt = 0;
  bit e_spike = 0, e_sat = 0, e_ref = 0;

  lif_membrane_stage #(
    .N(N), .REFRAC_STEPS(RS), .LEAK_SHIFT(LSHIFT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .sum_in(sum_in),
    .thresh(thresh), .mem_out(mem_out), .spike(spike), .sat(sat),
    .refrac(refrac), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock given the inputs for that clock.
  task automatic modelStep(input bit r, input bit v, input int s, input int th);
    int clamped, m;
    if (r) begin
      m_mem = 0; m_spike = 0; m_sat = 0; m_inref = 0; m_rem = 0; m_cnt = 0;
      return;
    end
    m_spike = 0;
    m_sat = 0;
    if (!v) return;
    if (!m_inref) begin
      clamped = (s > 15) ? 15 : s;
      m = clamped;
`ifdef LIF_LEAK_EN
      m = clamped - clamped / (1 << LSHIFT);
`endif
      m_sat = (s > 15);
      if (m >= th) begin
        m_mem = 0;
        m_spike = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        if (RS > 0) begin
          m_inref = 1;
          m_rem = RS;
        end
      end else begin
        m_mem = m;
      end
    end else begin
      m_mem = 0;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_inref = 0;
    end
  endtask

  // Drive one clock of inputs, advance the model and publish expectations.
  task automatic applyStimulus(input bit r, input bit v, input int s, input int th);
    @(negedge clk);
    rst = r;
    step_valid = v;
    sum_in = 5'(s);
    thresh = 4'(th);
    modelStep(r, v, s, th);
    @(posedge clk);
    #1;
    e_mem = m_mem; e_spike = m_spike; e_sat = m_sat;
    e_ref = m_inref; e_cnt = m_cnt;
    checking = 1'b1;
    step_valid = 1'b0;
  endtask

  // Emulate the upstream adder: A is the membrane, B the synaptic input.
  task automatic stepAdd(input int b, input int th);
    applyStimulus(0, 1, m_mem + b, th);
  endtask

  task automatic compareOne(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    compareOne("mem_out", int'(mem_out), e_mem);
    compareOne("spike", int'(spike), int'(e_spike));
    compareOne("sat", int'(sat), int'(e_sat));
    compareOne("refrac", int'(refrac), int'(e_ref));
    compareOne("spike_count", int'(spike_count), e_cnt);
  endtask

  // Every cycle after the first reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (checking) checkOutput();
  end

  // Directed scenarios pinned with literal values, then random traffic.
  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 10);
    compareOne("lit_reset_mem", int'(mem_out), 0);
    compareOne("lit_reset_cnt", int'(spike_count), 0);

`ifndef LIF_LEAK_EN
    stepAdd(3, 10); compareOne("lit_int1", int'(mem_out), 3);
    stepAdd(3, 10); compareOne("lit_int2", int'(mem_out), 6);
    stepAdd(3, 10); compareOne("lit_int3", int'(mem_out), 9);
    stepAdd(3, 10);
    compareOne("lit_fire_spike", int'(spike), 1);
    compareOne("lit_fire_mem", int'(mem_out), 0);
    compareOne("lit_fire_refrac", int'(refrac), 1);
    compareOne("lit_fire_cnt", int'(spike_count), 1);
    stepAdd(3, 10);
    compareOne("lit_ref1_mem", int'(mem_out), 0);
    compareOne("lit_ref1_refrac", int'(refrac), 1);
    stepAdd(3, 10);
    compareOne("lit_ref2_mem", int'(mem_out), 0);
    stepAdd(3, 10);
    compareOne("lit_post_mem", int'(mem_out), 3);
    compareOne("lit_post_refrac", int'(refrac), 0);
    stepAdd(11, 15); compareOne("lit_pre_sat_mem", int'(mem_out), 14);
    applyStimulus(0, 1, 5'b10011, 15);
    compareOne("lit_sat_sat", int'(sat), 1);
    compareOne("lit_sat_spike", int'(spike), 1);
    compareOne("lit_sat_mem", int'(mem_out), 0);
    stepAdd(2, 0);
    stepAdd(2, 0);
    stepAdd(0, 0); compareOne("lit_th0_spike_a", int'(spike), 1);
    stepAdd(1, 0);
    applyStimulus(1, 1, 7, 0);
    compareOne("lit_rst_mem", int'(mem_out), 0);
    compareOne("lit_rst_refrac", int'(refrac), 0);
    compareOne("lit_rst_cnt", int'(spike_count), 0);
    stepAdd(5, 15);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, $urandom_range(0, 31), 15);
      compareOne("lit_idle_mem", int'(mem_out), 5);
      compareOne("lit_idle_spike", int'(spike), 0);
      compareOne("lit_idle_sat", int'(sat), 0);
    end
`else
    applyStimulus(0, 1, 12, 15); compareOne("lit_leak12", int'(mem_out), 9);
    applyStimulus(0, 1, 3, 15);  compareOne("lit_leak3", int'(mem_out), 3);
`endif

    for (int i = 0; i < 600; i++) begin
      bit r, v;
      int s, th;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: th = 0;
        1: th = 15;
        default: th = $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 1) == 0)
        s = m_mem + $urandom_range(0, 15);
      else
        s = $urandom_range(0, 31);
      applyStimulus(r, v, s, th);
    end

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
